// File: rtl/rotate_right_serial_if.sv
// ----------------------------------------------------------------------------
// rotate_right_serial_if
//   Bundles the request/response signals of the serial rotate-right unit.
//   clk and rst are not part of the bundle. They are plain ports on the unit.
//
//   Signals:
//     in_valid   requester -> unit   a/b hold a valid request this cycle
//     in_ready   unit -> requester   unit can accept a request this cycle
//     a          requester -> unit   operand to rotate
//     b          requester -> unit   rotate-right amount, 0..WIDTH-1
//     out_valid  unit -> consumer    out holds a finished result
//     out_ready  consumer -> unit    consumer accepts out this cycle
//     out        unit -> consumer    rotated result (registered)
//     busy       unit -> requester   a request is in flight
//     state_dbg  unit -> observer    current FSM state, for checkers
//
//   Modports:
//     master  the requester/consumer side (ALU sequencer or testbench)
//     slave   the rotate unit itself
// ----------------------------------------------------------------------------
interface rotate_right_serial_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [AMT_W-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic [1:0]       state_dbg;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, busy, state_dbg
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, busy, state_dbg
    );
endinterface

// File: rtl/rotate_right_serial.sv
// ----------------------------------------------------------------------------
// rotate_right_serial
//   Multi-cycle rotate-right unit. It rotates operand a right by b places,
//   moving one bit position per clock. It holds one operation at a time and
//   keeps the result until the consumer accepts it.
//
//   Ports:
//     clk   clock; all state updates on the rising edge
//     rst   synchronous, active-high reset; aborts any operation in flight
//     bus   rotate_right_serial_if.slave (in_valid/in_ready/a/b,
//           out_valid/out_ready/out, busy, state_dbg)
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. A requester holds valid (and its data) until that edge. The
//   unit never makes ready depend on valid. Here in_ready and busy decode
//   from the state alone, and out_valid/out stay constant while
//   out_valid=1 and out_ready=0.
//
//   Timing: a request accepted on edge T with amount b raises out_valid
//   right after edge T+b. Counting the accept cycle as cycle 0, out_valid
//   is first seen in cycle b+1.
// ----------------------------------------------------------------------------
module rotate_right_serial #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input logic clk,
    input logic rst,
    rotate_right_serial_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg;
    logic [AMT_W-1:0] count;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] shreg_rot;
    logic             accept;
    logic             last_shift;

    assign shreg_rot  = {shreg[0], shreg[WIDTH-1:1]};
    assign accept     = (state_q == IDLE) && bus.in_valid;
    assign last_shift = (state_q == SHIFT) && (count == AMT_W'(1));

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = (bus.b == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (count == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg   <= '0;
            count   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                shreg <= bus.a;
                count <= bus.b;
            end else if (state_q == SHIFT) begin
                shreg <= shreg_rot;
                count <= count - AMT_W'(1);
            end
            // out_q is loaded only when a result completes. It therefore
            // still holds the previous result while the next operation shifts.
            if (accept && (bus.b == '0)) begin
                out_q <= bus.a;
            end else if (last_shift) begin
                out_q <= shreg_rot;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_rotate_right_serial.sv
// ----------------------------------------------------------------------------
// tb_rotate_right_serial
//   Self-checking bench for rotate_right_serial (WIDTH=8).
//   The reference model tracks one request in flight by its due edge number.
//   It keeps expected results in a queue and the last consumed result.
//   A negedge compare process checks the DUT against the model every cycle.
// ----------------------------------------------------------------------------
module tb_rotate_right_serial;
    localparam int W = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rotate_right_serial_if #(.WIDTH(W), .AMT_W(AW)) bus ();

    rotate_right_serial #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec formulas, plain arithmetic truncated to W bits.
    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
        logic [W-1:0] r;
        r = (x >> n) | (x << (W - n));
        return r;
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int n);
        logic [W-1:0] r;
        r = (x << n) | (x >> (W - n));
        return r;
    endfunction

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    bit           model_live = 0;
    bit           m_inflight = 0;
    int           m_done_edge = 0;
    int           edge_n = 0;
    logic [W-1:0] m_last = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_inflight = 0;
            m_last     = '0;
            exp_q.delete();
            model_live = 1;
        end else if (model_live) begin
            if (!m_inflight) begin
                if (bus.in_valid) begin
                    exp_q.push_back(rotr(bus.a, int'(bus.b)));
                    m_done_edge = edge_n + 1 + int'(bus.b);
                    m_inflight  = 1;
                end
            end else if ((edge_n >= m_done_edge) && bus.out_ready) begin
                m_last     = exp_q.pop_front();
                m_inflight = 0;
            end
        end
        edge_n++;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (model_live) begin
            bit exp_valid;
            exp_valid = m_inflight && (edge_n >= m_done_edge);
            chk("in_ready", 32'(bus.in_ready), 32'(!m_inflight));
            chk("busy", 32'(bus.busy), 32'(m_inflight));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            if (exp_valid && exp_q.size() > 0)
                chk("out", 32'(bus.out), 32'(exp_q[0]));
            else if (!exp_valid)
                chk("out_hold", 32'(bus.out), 32'(m_last));
        end
    end

    // ---------------- driver ----------------
    // Issues one request and measures its latency. It then stalls the
    // consumer for 'stall' cycles, optionally presenting a junk request
    // during the stall, and finally accepts the result.
    task automatic run_op(input logic [W-1:0] av, input int bv, input int stall,
                          input bit junk, output logic [W-1:0] res);
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.a         = av;
        bus.b         = AW'(bv);
        bus.out_ready = 1'b0;
        @(negedge clk);
        // Changing a/b after the accept edge must not affect the result.
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = AW'($urandom);
        k = 0;
        while (!bus.out_valid && k < 40) begin
            chk("busy_shift", 32'({bus.busy, bus.in_ready}), 32'b10);
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k + 1), 32'(bv + 1));
        res = bus.out;
        for (int i = 0; i < stall; i++) begin
            if (junk) begin
                bus.in_valid = 1'b1;
                bus.a        = 8'hFF;
                bus.b        = 3'd1;
            end
            @(negedge clk);
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_out", 32'(bus.out), 32'(res));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("post_release_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] x;
        int           bv;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        // Literal pins on the model's formulas.
        chk("model_rotr_81_1", 32'(rotr(8'h81, 1)), 32'hC0);
        chk("model_rotr_96_4", 32'(rotr(8'h96, 4)), 32'h69);
        chk("model_rotr_01_7", 32'(rotr(8'h01, 7)), 32'h02);
        chk("model_rotl_02_7", 32'(rotl(8'h02, 7)), 32'h01);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out", 32'(bus.out), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);

        // Directed cases.
        run_op(8'h81, 1, 0, 0, r);
        chk("t1_out", 32'(r), 32'hC0);
        run_op(8'h96, 4, 0, 0, r);
        chk("t2_out", 32'(r), 32'h69);
        run_op(8'h5A, 0, 0, 0, r);
        chk("t3_out_b0", 32'(r), 32'h5A);
        run_op(8'h01, 7, 0, 0, r);
        chk("t3_out_b7", 32'(r), 32'h02);
        // Backpressure with an ignored request during the stall.
        run_op(8'h96, 4, 3, 1, r);
        chk("t4_out", 32'(r), 32'h69);

        // Reset in the middle of a shift.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 8'h96;
        bus.b        = 3'd4;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_out", 32'(bus.out), 32'd0);
        run_op(8'h3C, 3, 1, 0, r);
        chk("t5_after", 32'(r), 32'h87);

        // Random round trip through the left-rotate formula.
        for (int i = 0; i < 500; i++) begin
            x  = W'($urandom);
            bv = $urandom_range(0, W - 1);
            run_op(rotl(x, bv), bv, $urandom_range(0, 2), 1'($urandom_range(0, 1)), r);
            chk("roundtrip", 32'(r), 32'(x));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
